// File: rtl/fir_mac_sequencer_pkg.sv
// Shared state encoding, default widths and output saturation helper for the FIR MAC sequencer.
package fir_mac_sequencer_pkg;

   localparam int FIR_NTAPS   = 32;
   localparam int FIR_COEF_W  = 16;
   localparam int FIR_SAMP_W  = 16;
   localparam int FIR_ACC_W   = 32;
   localparam int FIR_OUT_W   = 16;
   localparam int FIR_SHIFT   = 15;
   localparam int FIR_MAC_LAT = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      DRAIN  = 2'd2,
      OUTPUT = 2'd3
   } fir_state_e;

   // Clamp a sign-extended value into the signed range of an out_w-bit word.
   function automatic logic signed [63:0] fir_sat(input logic signed [63:0] v,
                                                  input int unsigned        out_w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi) begin
         return hi;
      end else if (v < lo) begin
         return lo;
      end
      return v;
   endfunction

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Sample, coefficient ROM, MAC and output signals of the FIR MAC sequencer.
// master: the sequencer; slave: sample source, ROM, MAC and output formatter.
interface fir_mac_sequencer_if
   import fir_mac_sequencer_pkg::*;
#(
   parameter int NTAPS  = FIR_NTAPS,
   parameter int COEF_W = FIR_COEF_W,
   parameter int SAMP_W = FIR_SAMP_W,
   parameter int ACC_W  = FIR_ACC_W,
   parameter int OUT_W  = FIR_OUT_W
);
   localparam int AW = $clog2(NTAPS);

   logic                     sample_valid;
   logic signed [SAMP_W-1:0] sample;
   logic                     in_ready;
   logic [AW-1:0]            coef_addr;
   logic signed [COEF_W-1:0] coef_data;
   logic signed [COEF_W-1:0] mac_a;
   logic signed [SAMP_W-1:0] mac_b;
   logic                     mac_ce;
   logic                     mac_oload;
   logic signed [ACC_W-1:0]  mac_o;
   logic signed [OUT_W-1:0]  y;
   logic                     y_valid;
   logic                     overrun;
   logic                     clr_overrun;

   modport master (
      input  sample_valid, sample, coef_data, mac_o, clr_overrun,
      output in_ready, coef_addr, mac_a, mac_b, mac_ce, mac_oload, y, y_valid, overrun
   );

   modport slave (
      output sample_valid, sample, coef_data, mac_o, clr_overrun,
      input  in_ready, coef_addr, mac_a, mac_b, mac_ce, mac_oload, y, y_valid, overrun
   );

endinterface

// File: rtl/fir_mac_sequencer_delay_line.sv
// Circular sample delay line: one write port, one registered read port, cleared by reset.
module fir_delay_line #(
   parameter int NTAPS  = 32,
   parameter int SAMP_W = 16
)(
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             we,
   input  logic [$clog2(NTAPS)-1:0]         wr_addr,
   input  logic signed [SAMP_W-1:0]         wr_data,
   input  logic                             re,
   input  logic [$clog2(NTAPS)-1:0]         rd_addr,
   output logic signed [SAMP_W-1:0]         rd_data
);

   logic signed [SAMP_W-1:0] mem [NTAPS];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NTAPS; i++) begin
            mem[i] <= '0;
         end
         rd_data <= '0;
      end else begin
         if (we) begin
            mem[wr_addr] <= wr_data;
         end
         if (re) begin
            rd_data <= mem[rd_addr];
         end
      end
   end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexes one MAC as an NTAPS-tap FIR: store sample, issue taps, drain, emit scaled output.
// Define FIR_SATURATE_EN to clamp y instead of wrapping it.
//
//   state  | meaning
//   IDLE   | in_ready high, MAC held (ce low), waiting for sample_valid
//   ISSUE  | NTAPS cycles, k = coef_addr, reading x[n-k] from the delay line
//   DRAIN  | MAC_LAT+1 cycles letting the last operand reach the accumulator
//   OUTPUT | y_valid pulse with the scaled accumulator
module fir_mac_sequencer
   import fir_mac_sequencer_pkg::*;
#(
   parameter int NTAPS   = FIR_NTAPS,
   parameter int COEF_W  = FIR_COEF_W,
   parameter int SAMP_W  = FIR_SAMP_W,
   parameter int ACC_W   = FIR_ACC_W,
   parameter int OUT_W   = FIR_OUT_W,
   parameter int SHIFT   = FIR_SHIFT,
   parameter int MAC_LAT = FIR_MAC_LAT
)(
   input  logic                clk,
   input  logic                reset_n,
   fir_mac_sequencer_if.master bus
);

   localparam int AW = $clog2(NTAPS);
   localparam int DW = $clog2(MAC_LAT + 2);

   fir_state_e state_q, state_d;
   logic [AW-1:0] k_q, k_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [DW-1:0] drain_q, drain_d;
   logic          op_vld_q;
   logic          oload_q;
   logic          overrun_q;
   logic signed [OUT_W-1:0] y_q;

   logic          dl_we;
   logic          dl_re;
   logic          load_y;
   logic          in_ready;
   logic          mac_ce;
   logic          y_valid;
   logic [AW-1:0] rd_addr;
   logic signed [SAMP_W-1:0] dl_rd_data;
   logic signed [COEF_W-1:0] coef_gated;
   logic signed [ACC_W-1:0]  acc_sh;
   logic signed [OUT_W-1:0]  y_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         k_q       <= '0;
         wr_ptr_q  <= '0;
         drain_q   <= '0;
         op_vld_q  <= 1'b0;
         oload_q   <= 1'b0;
         overrun_q <= 1'b0;
         y_q       <= '0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         wr_ptr_q <= wr_ptr_d;
         drain_q  <= drain_d;
         // Operand flags lag the issue cycle by the ROM / delay-line read latency.
         op_vld_q <= (state_q == ISSUE);
         oload_q  <= (state_q == ISSUE) && (k_q == '0);
         if (load_y) begin
            y_q <= y_nxt;
         end
         if (bus.sample_valid && !in_ready) begin
            overrun_q <= 1'b1;
         end else if (bus.clr_overrun) begin
            overrun_q <= 1'b0;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      wr_ptr_d = wr_ptr_q;
      drain_d  = drain_q;
      dl_we    = 1'b0;
      dl_re    = 1'b0;
      load_y   = 1'b0;
      in_ready = 1'b0;
      mac_ce   = 1'b1;
      y_valid  = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            mac_ce   = 1'b0;
            if (bus.sample_valid) begin
               dl_we   = 1'b1;
               k_d     = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            dl_re = 1'b1;
            k_d   = k_q + 1'b1;
            if (k_q == AW'(NTAPS - 1)) begin
               wr_ptr_d = wr_ptr_q + 1'b1;
               drain_d  = DW'(MAC_LAT);
               state_d  = DRAIN;
            end
         end
         DRAIN: begin
            if (drain_q == '0) begin
               load_y  = 1'b1;
               state_d = OUTPUT;
            end else begin
               drain_d = drain_q - 1'b1;
            end
         end
         OUTPUT: begin
            y_valid = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign rd_addr = wr_ptr_q - k_q;

   fir_delay_line #(
      .NTAPS  (NTAPS),
      .SAMP_W (SAMP_W)
   ) u_delay_line (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (dl_we),
      .wr_addr (wr_ptr_q),
      .wr_data (bus.sample),
      .re      (dl_re),
      .rd_addr (rd_addr),
      .rd_data (dl_rd_data)
   );

   assign acc_sh = bus.mac_o >>> SHIFT;

`ifdef FIR_SATURATE_EN
   logic signed [63:0] acc_sh_ext;
   assign acc_sh_ext = {{(64 - ACC_W){acc_sh[ACC_W-1]}}, acc_sh};
   assign y_nxt      = OUT_W'(fir_sat(acc_sh_ext, OUT_W));
`else
   assign y_nxt = OUT_W'(acc_sh);
`endif

   // ROM data and delay-line data arrive together one cycle after the issue cycle.
   assign coef_gated    = op_vld_q ? bus.coef_data : '0;
   assign bus.mac_a     = coef_gated;
   assign bus.mac_b     = op_vld_q ? dl_rd_data : '0;
   assign bus.mac_oload = oload_q;
   assign bus.mac_ce    = mac_ce;
   assign bus.coef_addr = k_q;
   assign bus.in_ready  = in_ready;
   assign bus.y         = y_q;
   assign bus.y_valid   = y_valid;
   assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with a coefficient ROM and two-stage MAC model.
module tb_fir_mac_sequencer;
   import fir_mac_sequencer_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   fir_mac_sequencer_if bus ();

   fir_mac_sequencer dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int tests = 0;
   int fails = 0;

   logic signed [15:0] rom [32];
   always @(posedge clk) bus.coef_data <= rom[bus.coef_addr];

   logic signed [15:0] ma_r, mb_r;
   logic               mol_r;
   logic signed [31:0] macc, prod;
   assign prod = ma_r * mb_r;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ma_r <= '0; mb_r <= '0; mol_r <= 1'b0; macc <= '0;
      end else if (bus.mac_ce) begin
         ma_r  <= bus.mac_a;
         mb_r  <= bus.mac_b;
         mol_r <= bus.mac_oload;
         macc  <= mol_r ? prod : macc + prod;
      end
   end
   assign bus.mac_o = macc;

   logic signed [15:0] yo;
   int                 lat, oloads;
   logic               rdy_after;

   task automatic do_reset();
      @(negedge clk); reset_n = 1'b0;
      @(negedge clk);
      @(negedge clk); reset_n = 1'b1;
   endtask

   task automatic run_sample(input logic signed [15:0] s, input int inj_at,
                             input logic signed [15:0] inj_s, input bit inj_clr,
                             output logic signed [15:0] y_o, output int lat_o,
                             output int ol_o, output logic rdy_o);
      int w;
      y_o = 'x; lat_o = -1; ol_o = 0; rdy_o = 1'bx; w = 0;
      while (bus.in_ready !== 1'b1 && w < 100) begin
         @(negedge clk); w++;
      end
      bus.sample = s; bus.sample_valid = 1'b1;
      @(posedge clk);
      for (int m = 0; m < 100; m++) begin
         @(negedge clk);
         if (m == 0) begin bus.sample_valid = 1'b0; rdy_o = bus.in_ready; end
         if (m == inj_at) begin
            bus.sample = inj_s; bus.sample_valid = 1'b1; bus.clr_overrun = inj_clr;
         end
         if (m == inj_at + 1) begin bus.sample_valid = 1'b0; bus.clr_overrun = 1'b0; end
         if (bus.mac_oload === 1'b1) ol_o++;
         if (bus.y_valid === 1'b1) begin y_o = bus.y; lat_o = m; break; end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
      tests++; if (bus.y_valid !== 1'b0) begin fails++; $display("FAIL rst_y_valid got=%b exp=0", bus.y_valid); end
      tests++; if (bus.y !== 16'sd0) begin fails++; $display("FAIL rst_y got=%0d exp=0", bus.y); end
      tests++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL rst_overrun got=%b exp=0", bus.overrun); end
      tests++; if (bus.mac_ce !== 1'b0) begin fails++; $display("FAIL rst_mac_ce got=%b exp=0", bus.mac_ce); end
      tests++; if (bus.mac_oload !== 1'b0) begin fails++; $display("FAIL rst_mac_oload got=%b exp=0", bus.mac_oload); end
      tests++; if (bus.mac_a !== 16'sd0) begin fails++; $display("FAIL rst_mac_a got=%0d exp=0", bus.mac_a); end
      tests++; if (bus.mac_b !== 16'sd0) begin fails++; $display("FAIL rst_mac_b got=%0d exp=0", bus.mac_b); end
      tests++; if (bus.coef_addr !== 5'd0) begin fails++; $display("FAIL rst_coef_addr got=%0d exp=0", bus.coef_addr); end
      reset_n = 1'b1;
      @(negedge clk);
      tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rel_in_ready got=%b exp=1", bus.in_ready); end
   endtask

   task automatic test_impulse_latency();
      for (int i = 0; i < 32; i++) rom[i] = 16'(i + 1);
      for (int n = 0; n < 32; n++) begin
         run_sample((n == 0) ? 16'sd32767 : 16'sd0, -1, 16'sd0, 1'b0, yo, lat, oloads, rdy_after);
         if (n == 0) begin
            tests++; if (lat !== 35) begin fails++; $display("FAIL latency got=%0d exp=35", lat); end
            tests++; if (oloads !== 1) begin fails++; $display("FAIL oload_cycles got=%0d exp=1", oloads); end
            tests++; if (rdy_after !== 1'b0) begin fails++; $display("FAIL in_ready_drop got=%b exp=0", rdy_after); end
            tests++; if (bus.y_valid !== 1'b0) begin fails++; $display("FAIL y_valid_pulse got=%b exp=0", bus.y_valid); end
         end
         tests++; if (yo !== n) begin fails++; $display("FAIL impulse[%0d] got=%0d exp=%0d", n, yo, n); end
      end
   endtask

   task automatic test_dc_step();
      int e;
      for (int i = 0; i < 32; i++) rom[i] = 16'sd1024;
      for (int j = 0; j < 33; j++) begin
         run_sample(16'sd1000, -1, 16'sd0, 1'b0, yo, lat, oloads, rdy_after);
         e = (((j < 32) ? j + 1 : 32) * 1024000) >>> 15;
         tests++; if (yo !== e) begin fails++; $display("FAIL dc[%0d] got=%0d exp=%0d", j, yo, e); end
      end
      tests++; if (yo !== 16'sd1000) begin fails++; $display("FAIL dc_settled got=%0d exp=1000", yo); end
   endtask

   task automatic test_overrun();
      run_sample(16'sd1000, 5, -16'sd20000, 1'b0, yo, lat, oloads, rdy_after);
      tests++; if (bus.overrun !== 1'b1) begin fails++; $display("FAIL overrun_set got=%b exp=1", bus.overrun); end
      tests++; if (yo !== 16'sd1000) begin fails++; $display("FAIL overrun_y got=%0d exp=1000", yo); end
      run_sample(16'sd1000, -1, 16'sd0, 1'b0, yo, lat, oloads, rdy_after);
      tests++; if (yo !== 16'sd1000) begin fails++; $display("FAIL overrun_dropped got=%0d exp=1000", yo); end
      tests++; if (bus.overrun !== 1'b1) begin fails++; $display("FAIL overrun_sticky got=%b exp=1", bus.overrun); end
      bus.clr_overrun = 1'b1; @(negedge clk); bus.clr_overrun = 1'b0;
      tests++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL overrun_clr got=%b exp=0", bus.overrun); end
      run_sample(16'sd1000, 5, -16'sd20000, 1'b1, yo, lat, oloads, rdy_after);
      tests++; if (bus.overrun !== 1'b1) begin fails++; $display("FAIL overrun_set_wins got=%b exp=1", bus.overrun); end
      bus.clr_overrun = 1'b1; @(negedge clk); bus.clr_overrun = 1'b0;
      tests++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL overrun_clr2 got=%b exp=0", bus.overrun); end
   endtask

   task automatic test_saturation();
      logic signed [15:0] e_pos, e_neg;
`ifdef FIR_SATURATE_EN
      e_pos = 16'sd32767; e_neg = -16'sd32768;
`else
      e_pos = -16'sd4;    e_neg = 16'sd3;
`endif
      for (int i = 0; i < 32; i++) rom[i] = 16'sd32767;
      do_reset();
      run_sample(16'sd32767, -1, 16'sd0, 1'b0, yo, lat, oloads, rdy_after);
      tests++; if (yo !== 16'sd32766) begin fails++; $display("FAIL sat_pos1 got=%0d exp=32766", yo); end
      run_sample(16'sd32767, -1, 16'sd0, 1'b0, yo, lat, oloads, rdy_after);
      tests++; if (yo !== e_pos) begin fails++; $display("FAIL sat_pos2 got=%0d exp=%0d", yo, e_pos); end
      do_reset();
      run_sample(-16'sd32767, -1, 16'sd0, 1'b0, yo, lat, oloads, rdy_after);
      tests++; if (yo !== -16'sd32767) begin fails++; $display("FAIL sat_neg1 got=%0d exp=-32767", yo); end
      run_sample(-16'sd32767, -1, 16'sd0, 1'b0, yo, lat, oloads, rdy_after);
      tests++; if (yo !== e_neg) begin fails++; $display("FAIL sat_neg2 got=%0d exp=%0d", yo, e_neg); end
   endtask

   task automatic test_reset_mid_issue();
      bit found;
      int w;
      for (int i = 0; i < 32; i++) rom[i] = 16'(i + 1);
      w = 0;
      while (bus.in_ready !== 1'b1 && w < 100) begin @(negedge clk); w++; end
      bus.sample = 16'sd12345; bus.sample_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      @(negedge clk); bus.sample_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (bus.coef_addr === 5'd10) begin found = 1'b1; break; end
         @(negedge clk);
      end
      tests++; if (found !== 1'b1) begin fails++; $display("FAIL mid_reach_k10 got=%b exp=1", found); end
      tests++; if (bus.overrun !== 1'b1) begin fails++; $display("FAIL mid_overrun_pre got=%b exp=1", bus.overrun); end
      reset_n = 1'b0;
      #1;
      tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL mid_in_ready got=%b exp=1", bus.in_ready); end
      tests++; if (bus.y_valid !== 1'b0) begin fails++; $display("FAIL mid_y_valid got=%b exp=0", bus.y_valid); end
      tests++; if (bus.y !== 16'sd0) begin fails++; $display("FAIL mid_y got=%0d exp=0", bus.y); end
      tests++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL mid_overrun got=%b exp=0", bus.overrun); end
      tests++; if (bus.mac_ce !== 1'b0) begin fails++; $display("FAIL mid_mac_ce got=%b exp=0", bus.mac_ce); end
      tests++; if (bus.mac_oload !== 1'b0) begin fails++; $display("FAIL mid_mac_oload got=%b exp=0", bus.mac_oload); end
      tests++; if (bus.mac_a !== 16'sd0) begin fails++; $display("FAIL mid_mac_a got=%0d exp=0", bus.mac_a); end
      tests++; if (bus.mac_b !== 16'sd0) begin fails++; $display("FAIL mid_mac_b got=%0d exp=0", bus.mac_b); end
      tests++; if (bus.coef_addr !== 5'd0) begin fails++; $display("FAIL mid_coef_addr got=%0d exp=0", bus.coef_addr); end
      @(negedge clk);
      @(negedge clk); reset_n = 1'b1;
      @(negedge clk);
      for (int n = 0; n < 4; n++) begin
         run_sample((n == 0) ? 16'sd32767 : 16'sd0, -1, 16'sd0, 1'b0, yo, lat, oloads, rdy_after);
         tests++; if (yo !== n) begin fails++; $display("FAIL post_reset_impulse[%0d] got=%0d exp=%0d", n, yo, n); end
      end
   endtask

   initial begin
      bus.sample_valid = 1'b0;
      bus.sample       = '0;
      bus.clr_overrun  = 1'b0;
      for (int i = 0; i < 32; i++) rom[i] = '0;
      @(negedge clk);
      test_reset();
      test_impulse_latency();
      test_dc_step();
      test_overrun();
      test_saturation();
      test_reset_mid_issue();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
